// File: rtl/q_cycle_sequencer_pkg.sv
// Shared widths, fetch/execute state codes and the EX_Q4 instruction classes.
package q_cycle_sequencer_pkg;

    localparam int INST_WIDTH    = 12;
    localparam int FE_STATE_BITS = 2;
    localparam int EX_STATE_BITS = 5;

    // Fetch phase code equals the phase number within the instruction cycle.
    typedef enum logic [FE_STATE_BITS-1:0] {
        FE_Q1 = 2'd0,
        FE_Q2 = 2'd1,
        FE_Q3 = 2'd2,
        FE_Q4 = 2'd3
    } fe_state_e;

    // Execute code: plain phases for Q1..Q3, decoded instruction class in Q4.
    typedef enum logic [EX_STATE_BITS-1:0] {
        EX_Q1        = 5'd0,
        EX_Q2        = 5'd1,
        EX_Q3        = 5'd2,
        EX_Q4_NOP    = 5'd3,
        EX_Q4_OPTION = 5'd4,
        EX_Q4_SLEEP  = 5'd5,
        EX_Q4_CLRWDT = 5'd6,
        EX_Q4_TRIS   = 5'd7,
        EX_Q4_MOVWF  = 5'd8,
        EX_Q4_CLRW   = 5'd9,
        EX_Q4_CLRF   = 5'd10,
        EX_Q4_MOVF   = 5'd11,
        EX_Q4_FSZ    = 5'd12,
        EX_Q4_ELSE   = 5'd13,
        EX_Q4_BXF    = 5'd14,
        EX_Q4_BTFSX  = 5'd15,
        EX_Q4_RETLW  = 5'd16,
        EX_Q4_CALL   = 5'd17,
        EX_Q4_GOTO   = 5'd18,
        EX_Q4_ALUXLW = 5'd19
    } ex_state_e;

    // Core run state: running normally, or frozen by SLEEP until wake.
    typedef enum logic {
        RUN_S   = 1'b0,
        SLEEP_S = 1'b1
    } run_state_e;

endpackage

// File: rtl/q_cycle_sequencer_ex_q4_decoder.sv
// Combinational decode of the executing instruction word into its EX_Q4 class.
module q_cycle_sequencer_ex_q4_decoder
    import q_cycle_sequencer_pkg::*;
(
    input  logic [INST_WIDTH-1:0] ir,
    output ex_state_e             q4_class
);

    // Classify by the top opcode bits; undefined encodings fall to NOP.
    always_comb begin
        q4_class = EX_Q4_NOP;
        case (ir[11:10])
            2'b00: begin
                case (ir[9:6])
                    4'b0000: begin
                        if (ir[5]) begin
                            q4_class = EX_Q4_MOVWF;
                        end else begin
                            case (ir[4:0])
                                5'h02:               q4_class = EX_Q4_OPTION;
                                5'h03:               q4_class = EX_Q4_SLEEP;
                                5'h04:               q4_class = EX_Q4_CLRWDT;
                                5'h05, 5'h06, 5'h07: q4_class = EX_Q4_TRIS;
                                default:             q4_class = EX_Q4_NOP;
                            endcase
                        end
                    end
                    4'b0001: begin
                        if (ir[5])
                            q4_class = EX_Q4_CLRF;
                        else if (ir[4:0] == 5'h00)
                            q4_class = EX_Q4_CLRW;
                        else
                            q4_class = EX_Q4_NOP;
                    end
                    4'b1000:          q4_class = EX_Q4_MOVF;
                    4'b1011, 4'b1111: q4_class = EX_Q4_FSZ;
                    default:          q4_class = EX_Q4_ELSE;
                endcase
            end
            2'b01: q4_class = ir[9] ? EX_Q4_BTFSX : EX_Q4_BXF;
            2'b10: begin
                case (ir[9:8])
                    2'b00:   q4_class = EX_Q4_RETLW;
                    2'b01:   q4_class = EX_Q4_CALL;
                    default: q4_class = EX_Q4_GOTO;
                endcase
            end
            default: q4_class = EX_Q4_ALUXLW;
        endcase
    end

endmodule

// File: rtl/q_cycle_sequencer.sv
// Four-phase fetch/execute timing controller with redirect bubble and SLEEP freeze.
module q_cycle_sequencer
    import q_cycle_sequencer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [INST_WIDTH-1:0]    IR,
    input  logic                     skip,
    input  logic                     goto,
    input  logic                     wakeIn,
    output logic [FE_STATE_BITS-1:0] fetchState,
    output logic [EX_STATE_BITS-1:0] executeState,
    output logic                     irLoad,
    output logic                     sleeping
);

    fe_state_e  fe_q, fe_d;
    ex_state_e  ex_q, ex_d;
    run_state_e state_q, state_d;
    logic       bubble_q, bubble_d;
    logic       ir_load_q, ir_load_d;
    ex_state_e  q4_class;

    q_cycle_sequencer_ex_q4_decoder u_ex_q4_decoder (
        .ir       (IR),
        .q4_class (q4_class)
    );

    // State and output registers; reset lands in Q1 with a pending bubble so
    // the first instruction cycle after reset executes as NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_q      <= FE_Q1;
            ex_q      <= EX_Q1;
            state_q   <= RUN_S;
            bubble_q  <= 1'b1;
            ir_load_q <= 1'b0;
        end else begin
            fe_q      <= fe_d;
            ex_q      <= ex_d;
            state_q   <= state_d;
            bubble_q  <= bubble_d;
            ir_load_q <= ir_load_d;
        end
    end

    // Next phase, Q4 class selection, bubble tracking and sleep/wake transitions.
    always_comb begin
        fe_d      = fe_q;
        ex_d      = ex_q;
        state_d   = state_q;
        bubble_d  = bubble_q;
        ir_load_d = 1'b0;
        case (state_q)
            RUN_S: begin
                case (fe_q)
                    FE_Q1: begin
                        fe_d = FE_Q2;
                        ex_d = EX_Q2;
                        // OR keeps the reset bubble alive; otherwise bubble is
                        // already clear here, so this is just skip|goto.
                        bubble_d = bubble_q | skip | goto;
                    end
                    FE_Q2: begin
                        fe_d = FE_Q3;
                        ex_d = EX_Q3;
                    end
                    FE_Q3: begin
                        fe_d      = FE_Q4;
                        ex_d      = bubble_q ? EX_Q4_NOP : q4_class;
                        ir_load_d = 1'b1;
                    end
                    FE_Q4: begin
                        bubble_d = 1'b0;
                        // A bubbled SLEEP already shows as NOP, so it never sleeps.
                        if (ex_q == EX_Q4_SLEEP) begin
                            state_d = SLEEP_S;
                            fe_d    = FE_Q2;
                            ex_d    = EX_Q2;
                        end else begin
                            fe_d = FE_Q1;
                            ex_d = EX_Q1;
                        end
                    end
                    default: begin
                        fe_d = FE_Q1;
                        ex_d = EX_Q1;
                    end
                endcase
            end
            SLEEP_S: begin
                // Hold Q2 codes (no PC increment) until a wake request arrives.
                if (wakeIn) begin
                    state_d = RUN_S;
                    fe_d    = FE_Q3;
                    ex_d    = EX_Q3;
                end
            end
            default: state_d = RUN_S;
        endcase
    end

    assign fetchState   = fe_q;
    assign executeState = ex_q;
    assign irLoad       = ir_load_q;
    assign sleeping     = (state_q == SLEEP_S);

endmodule

// File: tb/tb_q_cycle_sequencer.sv
// Directed bench for q_cycle_sequencer: phase sequencing, decode, bubble, sleep, reset.
module tb_q_cycle_sequencer;
    import q_cycle_sequencer_pkg::*;

    logic                     clk;
    logic                     rst_n;
    logic [INST_WIDTH-1:0]    ir;
    logic                     skip_i;
    logic                     goto_i;
    logic                     wake_in;
    logic [FE_STATE_BITS-1:0] fetch_state;
    logic [EX_STATE_BITS-1:0] execute_state;
    logic                     ir_load;
    logic                     sleeping;

    int n_compared;
    int n_mismatched;

    q_cycle_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IR           (ir),
        .skip         (skip_i),
        .goto         (goto_i),
        .wakeIn       (wake_in),
        .fetchState   (fetch_state),
        .executeState (execute_state),
        .irLoad       (ir_load),
        .sleeping     (sleeping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction cycle starting in FE_Q1: skip/goto held through EX_Q1 only.
    task automatic run_cycle(input string tag, input logic [11:0] word,
                             input logic sk, input logic gt, input ex_state_e exp_q4);
        ir     = word;
        skip_i = sk;
        goto_i = gt;
        tick();
        skip_i = 1'b0;
        goto_i = 1'b0;
        check({tag, "_fe2"}, fetch_state, FE_Q2);
        tick();
        tick();
        check({tag, "_fe4"}, fetch_state, FE_Q4);
        check({tag, "_q4"}, execute_state, exp_q4);
        check({tag, "_irload"}, ir_load, 1);
        tick();
    endtask

    typedef struct {
        logic [11:0] word;
        ex_state_e   cls;
    } dec_vec_t;

    dec_vec_t sweep[22];

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n   = 1'b0;
        ir      = 12'hC05;
        skip_i  = 1'b0;
        goto_i  = 1'b0;
        wake_in = 1'b0;

        sweep[0]  = '{12'h2E3, EX_Q4_FSZ};
        sweep[1]  = '{12'h6A1, EX_Q4_BTFSX};
        sweep[2]  = '{12'h905, EX_Q4_CALL};
        sweep[3]  = '{12'hA10, EX_Q4_GOTO};
        sweep[4]  = '{12'h1C4, EX_Q4_ELSE};
        sweep[5]  = '{12'h010, EX_Q4_NOP};
        sweep[6]  = '{12'h002, EX_Q4_OPTION};
        sweep[7]  = '{12'h004, EX_Q4_CLRWDT};
        sweep[8]  = '{12'h006, EX_Q4_TRIS};
        sweep[9]  = '{12'h040, EX_Q4_CLRW};
        sweep[10] = '{12'h050, EX_Q4_NOP};
        sweep[11] = '{12'h070, EX_Q4_CLRF};
        sweep[12] = '{12'h208, EX_Q4_MOVF};
        sweep[13] = '{12'h3C0, EX_Q4_FSZ};
        sweep[14] = '{12'h800, EX_Q4_RETLW};
        sweep[15] = '{12'h400, EX_Q4_BXF};
        sweep[16] = '{12'hE55, EX_Q4_ALUXLW};
        sweep[17] = '{12'hB00, EX_Q4_GOTO};
        sweep[18] = '{12'h001, EX_Q4_NOP};
        sweep[19] = '{12'h01F, EX_Q4_NOP};
        sweep[20] = '{12'h041, EX_Q4_NOP};
        sweep[21] = '{12'h000, EX_Q4_NOP};

        // Reset state, then release between clock edges.
        #12;
        check("rst_fe", fetch_state, FE_Q1);
        check("rst_ex", execute_state, EX_Q1);
        check("rst_irload", ir_load, 0);
        check("rst_sleeping", sleeping, 0);
        rst_n = 1'b1;

        // MOVLW 0x05: first cycle is the reset bubble, second decodes ALUXLW.
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 4; p++) begin
                check($sformatf("seq_c%0d_fe%0d", c, p + 1), fetch_state, p);
                check($sformatf("seq_c%0d_irload%0d", c, p + 1), ir_load, (p == 3) ? 1 : 0);
                if (p == 3)
                    check($sformatf("seq_c%0d_q4", c), execute_state,
                          (c == 0) ? EX_Q4_NOP : EX_Q4_ALUXLW);
                tick();
            end
        end
        check("seq_back_q1", fetch_state, FE_Q1);

        // Decode sweep.
        foreach (sweep[i])
            run_cycle($sformatf("dec_%03h", sweep[i].word), sweep[i].word, 1'b0, 1'b0, sweep[i].cls);

        // Skip bubble, then skip+goto together counts as one bubble.
        run_cycle("skip_bub", 12'h025, 1'b1, 1'b0, EX_Q4_NOP);
        run_cycle("skip_after", 12'h025, 1'b0, 1'b0, EX_Q4_MOVWF);
        run_cycle("both_bub", 12'h025, 1'b1, 1'b1, EX_Q4_NOP);
        run_cycle("both_after", 12'h025, 1'b0, 1'b0, EX_Q4_MOVWF);

        // Wake request while awake is ignored.
        wake_in = 1'b1;
        run_cycle("wake_awake", 12'hC05, 1'b0, 1'b0, EX_Q4_ALUXLW);
        wake_in = 1'b0;
        check("wake_awake_sleeping", sleeping, 0);

        // Bubbled SLEEP does not sleep.
        run_cycle("goto_sleep", 12'h003, 1'b0, 1'b1, EX_Q4_NOP);
        check("goto_sleep_sleeping", sleeping, 0);
        check("goto_sleep_fe", fetch_state, FE_Q1);

        // Real SLEEP: freeze at Q2 codes for 50 clocks, then wake into Q3.
        run_cycle("sleep", 12'h003, 1'b0, 1'b0, EX_Q4_SLEEP);
        ir = 12'h000;
        for (int k = 0; k < 50; k++) begin
            check($sformatf("slp%0d_sleeping", k), sleeping, 1);
            check($sformatf("slp%0d_fe", k), fetch_state, FE_Q2);
            check($sformatf("slp%0d_ex", k), execute_state, EX_Q2);
            check($sformatf("slp%0d_irload", k), ir_load, 0);
            tick();
        end
        wake_in = 1'b1;
        tick();
        wake_in = 1'b0;
        check("wake_sleeping", sleeping, 0);
        check("wake_fe3", fetch_state, FE_Q3);
        check("wake_ex3", execute_state, EX_Q3);
        tick();
        check("wake_fe4", fetch_state, FE_Q4);
        check("wake_q4", execute_state, EX_Q4_NOP);
        check("wake_irload", ir_load, 1);
        tick();
        check("wake_q1", fetch_state, FE_Q1);

        // Asynchronous reset in phase 3.
        ir = 12'hC05;
        tick();
        tick();
        check("pre_rst_fe3", fetch_state, FE_Q3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q3_fe", fetch_state, FE_Q1);
        check("arst_q3_ex", execute_state, EX_Q1);
        check("arst_q3_irload", ir_load, 0);
        check("arst_q3_sleeping", sleeping, 0);
        #2;
        rst_n = 1'b1;

        // Reset bubble masks SLEEP, next SLEEP freezes, then reset mid-sleep.
        run_cycle("rst_bub_sleep", 12'h003, 1'b0, 1'b0, EX_Q4_NOP);
        check("rst_bub_sleeping", sleeping, 0);
        run_cycle("sleep2", 12'h003, 1'b0, 1'b0, EX_Q4_SLEEP);
        tick();
        tick();
        check("sleep2_sleeping", sleeping, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_slp_fe", fetch_state, FE_Q1);
        check("arst_slp_ex", execute_state, EX_Q1);
        check("arst_slp_irload", ir_load, 0);
        check("arst_slp_sleeping", sleeping, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
